// File: rtl/vending_machine_param_if.sv
// Coin acceptor / actuator bundle for the parametrised vending machine.
// Change handshake: chg_half/chg_one are requests held stable until chg_ack; a coin transfers on an edge where request and chg_ack are both high.
interface vending_machine_param_if #(
  parameter int CW = 4
);
  logic          coin_half;
  logic          coin_one;
  logic          cancel;
  logic          chg_ack;
  logic [CW-1:0] credit;
  logic          cola;
  logic          chg_half;
  logic          chg_one;
  logic          coin_reject;
  logic          busy;
  logic [1:0]    fsm_state;

  modport master (
    output coin_half, coin_one, cancel, chg_ack,
    input  credit, cola, chg_half, chg_one, coin_reject, busy, fsm_state
  );

  modport slave (
    input  coin_half, coin_one, cancel, chg_ack,
    output credit, cola, chg_half, chg_one, coin_reject, busy, fsm_state
  );
endinterface

// File: rtl/vending_machine_param.sv
// Parametrised vending FSM: accumulates half/one coins, vends at PRICE,
// then pays change or a cancel refund largest coin first.
module vending_machine_param #(
  parameter int PRICE = 4,
  parameter int CW    = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  vending_machine_param_if.slave   bus
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          reject_q, reject_d;
  logic [CW-1:0] add, sum, dec;
  logic          coin_any, req_any;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    coin_any = bus.coin_half | bus.coin_one;
    add      = (bus.coin_one ? TWO_C : '0) + (bus.coin_half ? ONE_C : '0);
    sum      = credit_q + add;
    dec      = credit_q - ((credit_q >= TWO_C) ? TWO_C : ONE_C);
    req_any  = bus.chg_one | bus.chg_half;

    case (state_q)
      COLLECT: begin
        if (bus.cancel) begin
          // Cancel always wins over coins, even with nothing to refund.
          reject_d = coin_any;
          if (credit_q != '0) state_d = CHANGE;
        end else begin
          credit_d = sum;
          if (sum >= PRICE_C) state_d = VEND;
        end
      end
      VEND: begin
        reject_d = coin_any;
        credit_d = credit_q - PRICE_C;
        state_d  = (credit_q != PRICE_C) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        reject_d = coin_any;
        if (req_any && bus.chg_ack) begin
          credit_d = dec;
          if (dec == '0) state_d = COLLECT;
        end
      end
      default: begin
        state_d  = COLLECT;
        credit_d = '0;
      end
    endcase
  end

  assign bus.credit      = credit_q;
  assign bus.cola        = (state_q == VEND);
  assign bus.busy        = (state_q != COLLECT);
  assign bus.chg_one     = (state_q == CHANGE) && (credit_q >= TWO_C);
  assign bus.chg_half    = (state_q == CHANGE) && (credit_q == ONE_C);
  assign bus.coin_reject = reject_q;
  assign bus.fsm_state   = state_q;

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the fixed-price cola vending FSM.
- Accumulates half-unit and one-unit coins into a binary credit counter and dispenses one product when credit reaches PRICE.
- Returns change or a cancel refund through a req/ack coin-dispenser handshake, largest coin first.
- Sits between the coin-acceptor front end and the product/change actuators.

Parameters:
- PRICE, 4, product price in half-units (4 = 2.0). Legal range 1 to 2^CW-3.
- CW, 4, credit counter width. Must satisfy 2^CW-1 >= PRICE+2.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- coin_half  in  1  one-cycle pulse: a 0.5 coin was inserted.
- coin_one  in  1  one-cycle pulse: a 1.0 coin was inserted.
- cancel  in  1  one-cycle pulse: refund all current credit.
- chg_ack  in  1  dispenser has released the currently requested change coin.
- credit  out  CW  current credit in half-units (registered).
- cola  out  1  product dispense pulse, one cycle.
- chg_half  out  1  request to dispense one 0.5 coin; held until acked.
- chg_one  out  1  request to dispense one 1.0 coin; held until acked.
- coin_reject  out  1  registered pulse: coin(s) sampled this cycle were not accepted and must be returned by the acceptor.
- busy  out  1  high whenever the state is not COLLECT.

Behaviour:
- Reset (async, any state, mid-handshake included): state=COLLECT; credit=0; cola, chg_half, chg_one, coin_reject, busy all 0. Credit held at reset is discarded.
- States: COLLECT, VEND, CHANGE. All outputs except coin_reject are a Moore decode of the state/credit registers:
  - cola = (state==VEND)
  - busy = (state!=COLLECT)
  - chg_one = (state==CHANGE && credit>=2)
  - chg_half = (state==CHANGE && credit==1)
  - chg_one and chg_half are never high together.
- COLLECT:
  - add = coin_half*1 + coin_one*2; both pulses high in one cycle gives add=3.
  - cancel low: credit <= credit+add. If credit+add >= PRICE, next state is VEND; otherwise stay in COLLECT.
  - cancel high with credit>0: next state is CHANGE. Any coins in that cycle are not added and coin_reject pulses the next cycle.
  - cancel high with credit==0: cancel is ignored, but any coins in that cycle are still rejected (cancel wins).
  - Max credit entering VEND is PRICE+2, so no overflow is possible under the CW rule.
- VEND:
  - Lasts exactly one cycle. cola=1 during it.
  - At its closing edge, credit <= credit-PRICE.
  - Next state is CHANGE if the remainder is >0, otherwise COLLECT.
- CHANGE:
  - The request line is held stable until chg_ack.
  - On an edge with a request high and chg_ack high, credit decrements by 2 (chg_one) or 1 (chg_half).
  - When the decremented credit is 0, next state is COLLECT and the request drops in the same cycle credit reads 0.
  - chg_ack with no request high is ignored.
- Coins in VEND or CHANGE: not added; coin_reject=1 on the following cycle.
- cancel in VEND or CHANGE: ignored.
- Latency:
  - Coin in cycle n is visible on credit in n+1.
  - A coin completing the price gives cola high in n+1.
  - The first change request appears in n+2.
- coin_reject is high for one cycle per rejecting cycle. Back-to-back rejects give a continuous high.

Test Plan (PRICE=4, CW=4):
- Four coin_half pulses on separate cycles -> credit 1,2,3,4. cola high one cycle, one cycle after the 4th coin. credit returns to 0, no change requests, busy back to 0.
- coin_half then coin_one then coin_one -> credit 1,3,5. cola pulse, then credit 1. chg_half held through 3 cycles of chg_ack=0, then released on ack. credit 0, back to COLLECT.
- coin_one three times with coin_half+coin_one simultaneous on the 2nd -> credit 2, then 5 (VEND). Third coin arrives in VEND -> coin_reject pulse, credit unaffected. Change = one chg_half.
- Credit 3, then cancel -> CHANGE: chg_one, ack -> credit 1, chg_half, ack -> credit 0, COLLECT. Coin during CHANGE -> coin_reject, credit unchanged.
- Cancel simultaneous with coin_one at credit 2 -> coin rejected, refund of exactly 2 via one chg_one. Cancel at credit 0 -> no state change.
- Assert sys_rst_n low while chg_one is pending with credit 3 -> all outputs 0 immediately (async), credit 0, COLLECT after release. The next coin_half gives credit 1.
